// File: rtl/linear_embed_pkg.sv
// ---------------------------------------------------------------------------
// linear_embed_pkg
// Shared definitions for the linear embedding core:
//   state_t          - controller state encoding (IDLE / RUN / DONE)
//   DEF_*            - default parameter values for the core
//   saturate()       - clamps a wide signed value into a dw-bit signed range
// ---------------------------------------------------------------------------
package linear_embed_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam int DEF_ROWS = 15;
   localparam int DEF_COLS = 16;
   localparam int DEF_DW   = 8;
   localparam int DEF_FRAC = 4;
   localparam int DEF_SAT  = 1;

   // Clamp v to [-2^(dw-1), 2^(dw-1)-1]; result stays 64-bit signed so the
   // caller truncates to its own width.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/linear_embed_q_mac_sat.sv
// ---------------------------------------------------------------------------
// q_mac_sat
// Combinational fixed-point multiply / rescale / bias-add with optional
// saturation:  y = clamp_or_wrap( (a*b >>> FRAC) + bias ).
// Ports:
//   i_a, i_b  - signed DW-bit operands
//   i_bias    - signed DW-bit bias, sign-extended before the add
//   o_y       - signed DW-bit result
// ---------------------------------------------------------------------------
module q_mac_sat
   import linear_embed_pkg::*;
#(
   parameter int DW   = DEF_DW,
   parameter int FRAC = DEF_FRAC,
   parameter int SAT  = DEF_SAT
) (
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   input  logic [DW-1:0] i_bias,
   output logic [DW-1:0] o_y
);

   logic signed [2*DW-1:0] w_a_ext;
   logic signed [2*DW-1:0] w_b_ext;
   logic signed [2*DW-1:0] w_bias_ext;
   logic signed [2*DW-1:0] w_p;
   logic signed [2*DW-1:0] w_s;
   logic        [DW-1:0]   w_y_sat;
   logic        [DW-1:0]   w_y_wrap;

   assign w_a_ext    = {{DW{i_a[DW-1]}}, i_a};
   assign w_b_ext    = {{DW{i_b[DW-1]}}, i_b};
   assign w_bias_ext = {{DW{i_bias[DW-1]}}, i_bias};

   // Product of two DW-bit signed values always fits in 2*DW bits, and after
   // the >>> FRAC the bias add cannot overflow 2*DW either.
   assign w_p = w_a_ext * w_b_ext;
   assign w_s = (w_p >>> FRAC) + w_bias_ext;

   always_comb begin
      w_y_sat  = DW'(saturate(64'(w_s), DW));
      w_y_wrap = DW'(w_s);
      o_y      = (SAT != 0) ? w_y_sat : w_y_wrap;
   end

endmodule

// File: rtl/linear_embed_core.sv
// ---------------------------------------------------------------------------
// linear_embed_core
// Streams the outer product A x B plus a per-column bias as ROWS*COLS
// fixed-point elements, row-major (column index fastest), over a
// valid/ready handshake.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   start, abort         - begin a run (IDLE only) / cancel a run
//   mat_a                - ROWS packed signed DW-bit elements (A)
//   mat_b, bias          - COLS packed signed DW-bit elements (B, bias)
//   out_valid, out_ready - element handshake
//   out_data             - element value
//   out_row, out_col     - element index
//   busy                 - not IDLE
//   done                 - single-cycle completion pulse
// ---------------------------------------------------------------------------
module linear_embed_core
   import linear_embed_pkg::*;
#(
   parameter  int ROWS = DEF_ROWS,
   parameter  int COLS = DEF_COLS,
   parameter  int DW   = DEF_DW,
   parameter  int FRAC = DEF_FRAC,
   parameter  int SAT  = DEF_SAT,
   localparam int RW   = $clog2(ROWS),
   localparam int CW   = $clog2(COLS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [DW*ROWS-1:0]   mat_a,
   input  logic [DW*COLS-1:0]   mat_b,
   input  logic [DW*COLS-1:0]   bias,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic [RW-1:0]        out_row,
   output logic [CW-1:0]        out_col,
   output logic                 busy,
   output logic                 done
);

   state_t        r_state;
   logic [DW-1:0] r_a    [ROWS];
   logic [DW-1:0] r_b    [COLS];
   logic [DW-1:0] r_bias [COLS];
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;

   logic w_fire;
   logic w_last_row;
   logic w_last_col;

   assign out_valid  = (r_state == ST_RUN);
   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_DONE);
   assign out_row    = r_row;
   assign out_col    = r_col;

   assign w_fire     = out_valid && out_ready;
   assign w_last_row = (r_row == RW'(ROWS - 1));
   assign w_last_col = (r_col == CW'(COLS - 1));

   // Output is a pure function of the captured operands and the counters,
   // so it holds still for as long as the counters do (i.e. while stalled).
   q_mac_sat #(
      .DW   (DW),
      .FRAC (FRAC),
      .SAT  (SAT)
   ) u_mac (
      .i_a    (r_a[r_row]),
      .i_b    (r_b[r_col]),
      .i_bias (r_bias[r_col]),
      .o_y    (out_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         for (int i = 0; i < ROWS; i++) r_a[i] <= '0;
         for (int j = 0; j < COLS; j++) begin
            r_b[j]    <= '0;
            r_bias[j] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  for (int i = 0; i < ROWS; i++) r_a[i] <= mat_a[i*DW +: DW];
                  for (int j = 0; j < COLS; j++) begin
                     r_b[j]    <= mat_b[j*DW +: DW];
                     r_bias[j] <= bias[j*DW +: DW];
                  end
                  r_row   <= '0;
                  r_col   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Abort wins over a handshake in the same cycle.
               if (abort) begin
                  r_state <= ST_IDLE;
               end else if (w_fire) begin
                  if (w_last_col) begin
                     r_col <= '0;
                     if (w_last_row) begin
                        r_row   <= '0;
                        r_state <= ST_DONE;
                     end else begin
                        r_row <= r_row + 1'b1;
                     end
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_linear_embed_core.sv
// ---------------------------------------------------------------------------
// tb_linear_embed_core
// Directed bench for linear_embed_core: reset state, hand-computed
// saturation/rounding vectors (SAT=1 and SAT=0 instances), full runs with
// and without backpressure, abort, mid-run reset and back-to-back runs.
// ---------------------------------------------------------------------------
module tb_linear_embed_core;

   localparam int ROWS = 15;
   localparam int COLS = 16;
   localparam int DW   = 8;
   localparam int FRAC = 4;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic                 abort;
   logic [DW*ROWS-1:0]   mat_a;
   logic [DW*COLS-1:0]   mat_b;
   logic [DW*COLS-1:0]   bias;
   logic                 out_ready;
   logic                 out_valid;
   logic [DW-1:0]        out_data;
   logic [3:0]           out_row;
   logic [3:0]           out_col;
   logic                 busy;
   logic                 done;

   logic                 wr_valid;
   logic [DW-1:0]        wr_data;
   logic [3:0]           wr_row;
   logic [3:0]           wr_col;
   logic                 wr_busy;
   logic                 wr_done;

   int n_checks = 0;
   int n_errors = 0;

   linear_embed_core #(
      .ROWS (ROWS), .COLS (COLS), .DW (DW), .FRAC (FRAC), .SAT (1)
   ) u_dut (
      .clk (clk), .rst (rst), .start (start), .abort (abort),
      .mat_a (mat_a), .mat_b (mat_b), .bias (bias),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
      .out_row (out_row), .out_col (out_col), .busy (busy), .done (done)
   );

   linear_embed_core #(
      .ROWS (ROWS), .COLS (COLS), .DW (DW), .FRAC (FRAC), .SAT (0)
   ) u_dut_wrap (
      .clk (clk), .rst (rst), .start (start), .abort (abort),
      .mat_a (mat_a), .mat_b (mat_b), .bias (bias),
      .out_valid (wr_valid), .out_ready (out_ready), .out_data (wr_data),
      .out_row (wr_row), .out_col (wr_col), .busy (wr_busy), .done (wr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: product, floor divide by 2^FRAC, add bias, clamp or wrap.
   function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] bi, input bit sat);
      int p;
      int s;
      p = int'($signed(a)) * int'($signed(b));
      s = p / 16;
      if ((p < 0) && ((p % 16) != 0)) s = s - 1;
      s = s + int'($signed(bi));
      if (sat) begin
         if (s > 127)       s = 127;
         else if (s < -128) s = -128;
      end
      return s[7:0];
   endfunction

   task automatic fill_random();
      for (int i = 0; i < ROWS; i++) mat_a[i*DW +: DW] = 8'($urandom);
      for (int j = 0; j < COLS; j++) begin
         mat_b[j*DW +: DW] = 8'($urandom);
         bias[j*DW +: DW]  = 8'($urandom);
      end
   endtask

   // One element at (0,0) checked on both instances, then the run is aborted.
   task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] bi, input logic [7:0] exp_sat,
                         input logic [7:0] exp_wrap);
      fill_random();
      mat_a[7:0] = a;
      mat_b[7:0] = b;
      bias[7:0]  = bi;
      out_ready  = 1'b0;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "/sat"},  32'({out_valid, out_row, out_col, out_data}), 32'({1'b1, 8'h00, exp_sat}));
      check({tag, "/wrap"}, 32'({wr_valid, wr_data}), 32'({1'b1, exp_wrap}));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check({tag, "/idle"}, 32'({busy, wr_busy}), 32'd0);
   endtask

   task automatic run_check(input string tag, input int ready_pct, input int abort_at,
                            input int rst_at, input int first_exp);
      logic [7:0] exp_q [ROWS*COLS];
      int  k;
      int  n_vcyc;
      bit  fin;
      bit  ended_done;
      bit  ended_cut;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            exp_q[r*COLS+c] = model(mat_a[r*DW +: DW], mat_b[c*DW +: DW], bias[c*DW +: DW], 1'b1);
      start     = 1'b1;
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      start = 1'b0;
      check({tag, "/first_valid"}, 32'(out_valid), 32'd1);
      if (first_exp >= 0)
         check({tag, "/first_elem"}, 32'({out_row, out_col, out_data}), 32'({8'h00, first_exp[7:0]}));
      // Operands change while running; results must come from the captured copy.
      fill_random();
      k = 0; n_vcyc = 0; fin = 0; ended_done = 0; ended_cut = 0;
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         if (done) begin
            fin        = 1;
            ended_done = 1;
            check({tag, "/valid_at_done"}, 32'(out_valid), 32'd0);
            check({tag, "/handshakes"}, 32'(k), 32'(ROWS*COLS));
            if (ready_pct >= 100)
               check({tag, "/valid_cycles"}, 32'(n_vcyc), 32'(ROWS*COLS));
            @(negedge clk);
            check({tag, "/idle_after_done"}, 32'({done, busy, out_valid}), 32'd0);
         end else begin
            check({tag, "/busy_valid"}, 32'({busy, out_valid}), 32'd3);
            if (k < ROWS*COLS)
               check({tag, "/elem"}, 32'({out_row, out_col, out_data}),
                     32'({4'(k / COLS), 4'(k % COLS), exp_q[k]}));
            else
               check({tag, "/extra_elem"}, 32'(k), 32'(ROWS*COLS - 1));
            n_vcyc++;
            start     = (cyc == 3);
            out_ready = ($urandom_range(99) < ready_pct);
            if (k == abort_at) begin
               abort     = 1'b1;
               out_ready = 1'b1;
            end
            if (k == rst_at) rst = 1'b1;
            if (out_ready && !abort && !rst) k++;
            @(negedge clk);
            start = 1'b0;
            if (abort) begin
               abort     = 1'b0;
               fin       = 1;
               ended_cut = 1;
               check({tag, "/abort_idle"}, 32'({out_valid, busy, done}), 32'd0);
               for (int q = 0; q < 3; q++) begin
                  @(negedge clk);
                  check({tag, "/abort_quiet"}, 32'({out_valid, done}), 32'd0);
               end
            end else if (rst) begin
               rst       = 1'b0;
               fin       = 1;
               ended_cut = 1;
               check({tag, "/rst_zero"},
                     32'({out_valid, busy, done, out_data, out_row, out_col}), 32'd0);
               for (int q = 0; q < 3; q++) begin
                  @(negedge clk);
                  check({tag, "/rst_quiet"}, 32'({out_valid, done}), 32'd0);
               end
            end
         end
      end
      out_ready = 1'b0;
      check({tag, "/terminated"}, 32'(fin), 32'd1);
      if ((abort_at >= 0) || (rst_at >= 0))
         check({tag, "/cut_short"}, 32'({ended_cut, ended_done}), 32'd2);
      else
         check({tag, "/completed"}, 32'({ended_cut, ended_done}), 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      mat_a = '0; mat_b = '0; bias = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset/ctrl", 32'({out_valid, busy, done}), 32'd0);
      check("reset/data", 32'({out_data, out_row, out_col}), 32'd0);

      single("sat_pos",   8'h7F, 8'h7F, 8'h00, 8'h7F, 8'hF0);
      single("sat_neg",   8'h80, 8'h7F, 8'h00, 8'h80, 8'h08);
      single("neg_exact", 8'hF0, 8'h10, 8'h00, 8'hF0, 8'hF0);
      single("floor_pos", 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
      single("floor_neg", 8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFF);
      single("bias_add",  8'h10, 8'h20, 8'h08, 8'h28, 8'h28);

      fill_random();
      mat_a[7:0] = 8'h10; mat_b[7:0] = 8'h20; bias[7:0] = 8'h08;
      run_check("run_full", 100, -1, -1, 8'h28);

      // Starts in the IDLE cycle right after the previous run's done.
      fill_random();
      run_check("run_b2b_stall", 50, -1, -1, -1);

      fill_random();
      run_check("run_abort", 50, 37, -1, -1);

      fill_random();
      run_check("run_rst", 50, -1, 100, -1);

      fill_random();
      run_check("run_after_rst", 70, -1, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/linear_embed_core.md
LINEAR_EMBED_CORE -- requirements
Module: linear_embed_core

Interface
REQ-001 SHALL have parameter ROWS, default 15: number of elements in vector A (output rows).
REQ-002 SHALL have parameter COLS, default 16: number of elements in vector B and bias (output columns).
REQ-003 SHALL have parameter DW, default 8: signed fixed-point data width.
REQ-004 SHALL have parameter FRAC, default 4: fractional bits (default gives Q4.4).
REQ-005 SHALL have parameter SAT, default 1: 1 = saturate results, 0 = wrap results.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1: request to capture operands and begin.
REQ-009 SHALL have port abort, input, 1: cancel the run in progress.
REQ-010 SHALL have port mat_a, input, signed DW x ROWS: vector A.
REQ-011 SHALL have port mat_b, input, signed DW x COLS: vector B.
REQ-012 SHALL have port bias, input, signed DW x COLS: per-column bias.
REQ-013 SHALL have port out_valid, output, 1: out_data is valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the element.
REQ-015 SHALL have port out_data, output, signed DW: result element.
REQ-016 SHALL have ports out_row and out_col, output, clog2 widths: element index.
REQ-017 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on the last handshake; DONE->IDLE unconditionally after 1 cycle.
REQ-020 SHALL, on start in IDLE, register mat_a, mat_b and bias, and clear row and col counters to 0.
REQ-021 SHALL ignore start outside IDLE; changes to input operands during RUN SHALL NOT affect results.
REQ-022 SHALL assert out_valid in every RUN cycle and only then; the first element appears the cycle after start.
REQ-023 SHALL define element (i,j) as: p = A[i]*B[j] (2*DW signed), s = (p >>> FRAC) + sign-extended bias[j], computed at 2*DW width (arithmetic shift, floor rounding).
REQ-024 SHALL, when SAT=1, clamp s to [-2^(DW-1), 2^(DW-1)-1]; when SAT=0, output s[DW-1:0].
REQ-025 SHALL emit elements in row-major order, col fastest; counters advance only on out_valid&&out_ready.
REQ-026 SHALL, while out_ready is low, hold out_data, out_row and out_col stable.
REQ-027 SHALL, on handshake at (ROWS-1, COLS-1), go to DONE with done=1 for exactly one cycle and out_valid=0.
REQ-028 SHALL, on abort in RUN or DONE, return to IDLE next cycle with no done pulse and no further out_valid; abort SHALL take precedence over a simultaneous handshake.
REQ-029 SHALL accept a start asserted in the cycle after DONE (back-to-back runs with a 1-cycle IDLE gap).

Reset
REQ-030 SHALL, on rst, force state IDLE, counters 0, out_valid=0, done=0, busy=0; operand registers SHALL clear to 0.
REQ-031 SHALL, when rst is asserted mid-RUN, abandon the run with no done pulse; rst SHALL override start and abort.

Structure
REQ-032 SHALL place state_t, the default parameter constants and a saturate function in package linear_embed_pkg.
REQ-033 SHALL implement REQ-023/024 in combinational sub-module q_mac_sat (parameters DW, FRAC, SAT), instanced once and driven by the operands selected by the counters.

Verification
REQ-034 The bench SHALL check: A[0]=0x10, B[0]=0x20, bias[0]=0x08, out_ready=1 -> first element 0x28 at (0,0) one cycle after start; done follows ROWS*COLS valid cycles.
REQ-035 The bench SHALL check saturation: A=0x7F, B=0x7F, bias=0 -> 0x7F with SAT=1 and 0xF0 with SAT=0; A=0x80, B=0x7F, SAT=1 -> 0x80.
REQ-036 The bench SHALL check sign and floor rounding: A=0xF0, B=0x10 -> 0xF0; A=0x01, B=0x01 -> 0x00; A=0xFF, B=0x01 -> 0xFF.
REQ-037 The bench SHALL check backpressure: random out_ready (~50%) -> all 240 elements in row-major order, none duplicated, data stable while stalled, exactly one done.
REQ-038 The bench SHALL check abort and reset: abort at element 37 -> IDLE next cycle, no done; rst at element 100 -> all outputs 0 the next cycle; a start during RUN is ignored.
REQ-039 The bench SHALL check back-to-back runs: start in the cycle after done with new operands -> second run uses the new operands; operand changes mid-run do not alter outputs.
